// File: rtl/mcu_el2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mcu_el2_pkg                                        |
// | Description : Shared types for the EL2 trace port and the trace  |
// |               capture buffer (packet, stored record, word-0 map) |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package mcu_el2_pkg;

  // Per-retirement trace packet as driven by the core
  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } mcu_el2_trace_pkt_t;

  localparam int SEQ_W = 16;

  // One stored ring-buffer entry
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic             exception;
    logic             interrupt;
    logic [4:0]       ecause;
    logic [31:0]      insn;
    logic [31:0]      address;
    logic [31:0]      tval;
  } mcu_el2_trace_rec_t;

  // Field positions inside serialized word 0; bits [24:16] are reserved zero
  localparam int W0_EXC_BIT    = 31;
  localparam int W0_INTR_BIT   = 30;
  localparam int W0_ECAUSE_MSB = 29;
  localparam int W0_ECAUSE_LSB = 25;
  localparam int W0_SEQ_MSB    = 15;
  localparam int W0_SEQ_LSB    = 0;

  // Build the header word of a stored entry
  function automatic logic [31:0] trace_word0(input mcu_el2_trace_rec_t rec);
    logic [31:0] w;
    w = '0;
    w[W0_EXC_BIT]                  = rec.exception;
    w[W0_INTR_BIT]                 = rec.interrupt;
    w[W0_ECAUSE_MSB:W0_ECAUSE_LSB] = rec.ecause;
    w[W0_SEQ_MSB:W0_SEQ_LSB]       = rec.seq;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_el2_trace_ring.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mcu_el2_trace_ring                                 |
// | Description : Ring buffer of trace records with read/write       |
// |               pointers, occupancy count and an evict-oldest path |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module mcu_el2_trace_ring
  import mcu_el2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     drop_oldest,
  input  mcu_el2_trace_rec_t       wr_rec,
  output mcu_el2_trace_rec_t       head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mcu_el2_trace_rec_t mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               adv_rd;

  // Popping a read-out entry and evicting the oldest both retire the head
  assign adv_rd = pop | drop_oldest;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_rec;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (adv_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, adv_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/mcu_el2_trace_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mcu_el2_trace_capture                              |
// | Description : EL2 trace sink: packet filter, sequence numbering, |
// |               ring storage and 4-word valid/ready serializer     |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module mcu_el2_trace_capture
  import mcu_el2_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  mcu_el2_trace_pkt_t      trace_pkt,
  input  logic                    cfg_en,
  input  logic                    cfg_wrap,
  input  logic                    cfg_exc_only,
  input  logic                    clear,
  output logic                    out_valid,
  output logic [31:0]             out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic [DROP_W-1:0]       drop_cnt
);

  logic [SEQ_W-1:0]   seq;
  logic [1:0]         widx;
  mcu_el2_trace_rec_t wr_rec;
  mcu_el2_trace_rec_t head;

  logic qualify;
  logic hs;
  logic pop_w3;
  logic wrap_evict;
  logic push;
  logic pop;
  logic drop_oldest;
  logic drop_event;

  assign qualify = cfg_en & trace_pkt.trace_rv_i_valid_ip &
                   (~cfg_exc_only | trace_pkt.trace_rv_i_exception_ip |
                    trace_pkt.trace_rv_i_interrupt_ip);

  assign hs     = out_valid & out_ready;
  assign pop_w3 = hs & (widx == 2'd3);

  // Eviction is only safe while the head has not been partially read
  assign wrap_evict  = full & ~pop_w3 & cfg_wrap & (widx == 2'd0);
  assign push        = qualify & ~clear & (~full | pop_w3 | wrap_evict);
  assign drop_oldest = qualify & ~clear & wrap_evict;
  assign drop_event  = qualify & ~clear & full & ~pop_w3;
  assign pop         = pop_w3 & ~clear;

  assign wr_rec.seq       = seq;
  assign wr_rec.exception = trace_pkt.trace_rv_i_exception_ip;
  assign wr_rec.interrupt = trace_pkt.trace_rv_i_interrupt_ip;
  assign wr_rec.ecause    = trace_pkt.trace_rv_i_ecause_ip;
  assign wr_rec.insn      = trace_pkt.trace_rv_i_insn_ip;
  assign wr_rec.address   = trace_pkt.trace_rv_i_address_ip;
  assign wr_rec.tval      = trace_pkt.trace_rv_i_tval_ip;

  mcu_el2_trace_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .push        (push),
    .pop         (pop),
    .drop_oldest (drop_oldest),
    .wr_rec      (wr_rec),
    .head        (head),
    .count       (count),
    .full        (full)
  );

  // Sequence number advances on every qualifying packet, stored or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq <= '0;
    end else if (clear) begin
      seq <= '0;
    end else if (qualify) begin
      seq <= seq + SEQ_W'(1);
    end
  end

  // Word index; an evicted head restarts framing at word 0 of the new head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx <= 2'd0;
    end else if (clear || drop_oldest) begin
      widx <= 2'd0;
    end else if (hs) begin
      widx <= widx + 2'd1;
    end
  end

  // Saturating count of qualifying packets that lost their slot or an entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (drop_event && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  assign out_valid = (count != '0);
  assign out_last  = out_valid & (widx == 2'd3);

  // Head-entry word mux, forced to zero when nothing is stored
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (widx)
        2'd0:    out_data = trace_word0(head);
        2'd1:    out_data = head.insn;
        2'd2:    out_data = head.address;
        default: out_data = head.tval;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcu_el2_trace_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_mcu_el2_trace_capture                           |
// | Description : Directed self-checking bench for the trace capture |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_mcu_el2_trace_capture;
  import mcu_el2_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  mcu_el2_trace_pkt_t     trace_pkt;
  logic                   cfg_en;
  logic                   cfg_wrap;
  logic                   cfg_exc_only;
  logic                   clear;
  logic                   out_valid;
  logic [31:0]            out_data;
  logic                   out_last;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic [DROP_W-1:0]      drop_cnt;

  int checks = 0;
  int errors = 0;

  mcu_el2_trace_capture #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trace_pkt    (trace_pkt),
    .cfg_en       (cfg_en),
    .cfg_wrap     (cfg_wrap),
    .cfg_exc_only (cfg_exc_only),
    .clear        (clear),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .count        (count),
    .full         (full),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input logic v, input logic exc, input logic intr,
                           input logic [4:0] ec, input logic [31:0] insn,
                           input logic [31:0] addr, input logic [31:0] tval);
    trace_pkt.trace_rv_i_valid_ip     = v;
    trace_pkt.trace_rv_i_exception_ip = exc;
    trace_pkt.trace_rv_i_interrupt_ip = intr;
    trace_pkt.trace_rv_i_ecause_ip    = ec;
    trace_pkt.trace_rv_i_insn_ip      = insn;
    trace_pkt.trace_rv_i_address_ip   = addr;
    trace_pkt.trace_rv_i_tval_ip      = tval;
  endtask

  task automatic do_clear();
    out_ready = 1'b0;
    trace_pkt = '0;
    clear     = 1'b1;
    tick();
    clear     = 1'b0;
  endtask

  // Plain packets numbered i: insn=0x100+i, addr=0x1000+4i, tval=0x5000+i
  task automatic fill(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      drive_pkt(1'b1, 1'b0, 1'b0, 5'd0, 32'h100 + 32'(i),
                32'h1000 + 32'(4 * i), 32'h5000 + 32'(i));
      tick();
    end
    trace_pkt = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; trace_pkt = '0; cfg_en = 1'b0; cfg_wrap = 1'b0;
    cfg_exc_only = 1'b0; clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_capture();
    logic [31:0] exp [4];
    exp = '{32'h0000_0000, 32'h0000_0013, 32'h8000_0000, 32'h0000_0000};
    cfg_en = 1'b1; out_ready = 1'b1;
    drive_pkt(1'b1, 1'b0, 1'b0, 5'd0, 32'h13, 32'h8000_0000, 32'h0);
    tick();
    trace_pkt = '0;
    for (int w = 0; w < 4; w++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid w%0d: got %b expected 1", w, out_valid); end
      checks++; if (out_data !== exp[w]) begin errors++; $display("FAIL basic_data w%0d: got %h expected %h", w, out_data, exp[w]); end
      checks++; if (out_last !== (w == 3)) begin errors++; $display("FAIL basic_last w%0d: got %b expected %b", w, out_last, (w == 3)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got valid %b expected 0", out_valid); end
  endtask

  task automatic test_exc_filter();
    logic [31:0] exp [4];
    // exc=1 (bit31), ecause=2 in [29:25], seq=0 since prior packets do not qualify
    exp = '{32'h8400_0000, 32'h0000_0073, 32'h0000_0100, 32'h0000_DEAD};
    do_clear();
    cfg_exc_only = 1'b1;
    drive_pkt(1'b1, 1'b0, 1'b0, 5'd0, 32'h11, 32'h40, 32'h0);       tick();
    drive_pkt(1'b1, 1'b1, 1'b0, 5'd2, 32'h73, 32'h100, 32'hDEAD);   tick();
    drive_pkt(1'b1, 1'b0, 1'b0, 5'd0, 32'h22, 32'h44, 32'h0);       tick();
    trace_pkt = '0;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL exc_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      checks++; if (out_data !== exp[w]) begin errors++; $display("FAIL exc_data w%0d: got %h expected %h", w, out_data, exp[w]); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exc_empty: got valid %b expected 0", out_valid); end
    cfg_exc_only = 1'b0;
  endtask

  task automatic test_overflow(input logic wrap, input int first_seq);
    logic [31:0] exp;
    do_clear();
    cfg_wrap = wrap;
    fill(0, 10);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf%0b_count: got %0d expected 8", wrap, count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf%0b_full: got %b expected 1", wrap, full); end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf%0b_drop: got %0d expected 2", wrap, drop_cnt); end
    out_ready = 1'b1;
    for (int e = first_seq; e < first_seq + 8; e++) begin
      for (int w = 0; w < 4; w++) begin
        case (w)
          0:       exp = 32'(e);
          1:       exp = 32'h100 + 32'(e);
          2:       exp = 32'h1000 + 32'(4 * e);
          default: exp = 32'h5000 + 32'(e);
        endcase
        checks++; if (out_data !== exp) begin errors++; $display("FAIL ovf%0b_data seq%0d w%0d: got %h expected %h", wrap, e, w, out_data, exp); end
        tick();
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf%0b_empty: got valid %b expected 0", wrap, out_valid); end
    cfg_wrap = 1'b0;
  endtask

  task automatic test_wrap_midread();
    do_clear();
    cfg_wrap = 1'b1;
    fill(0, 8);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    fill(8, 1);
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL mid_drop: got %0d expected 1", drop_cnt); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL mid_count: got %0d expected 8", count); end
    checks++; if (out_data !== 32'h0000_1000) begin errors++; $display("FAIL mid_w2: got %h expected 00001000", out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 32'h0000_5000) begin errors++; $display("FAIL mid_w3: got %h expected 00005000", out_data); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL mid_last: got %b expected 1", out_last); end
    tick();
    checks++; if (out_data !== 32'h0000_0001) begin errors++; $display("FAIL mid_next_w0: got %h expected 00000001", out_data); end
    cfg_wrap = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_clear();
    fill(0, 8);
    out_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL pp_last: got %b expected 1", out_last); end
    fill(8, 1);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL pp_count: got %0d expected 8", count); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL pp_drop: got %0d expected 0", drop_cnt); end
    checks++; if (out_data !== 32'h0000_0001) begin errors++; $display("FAIL pp_head: got %h expected 00000001", out_data); end
    for (int i = 0; i < 28; i++) tick();
    checks++; if (out_data !== 32'h0000_0008) begin errors++; $display("FAIL pp_tail_w0: got %h expected 00000008", out_data); end
    tick();
    checks++; if (out_data !== 32'h0000_0108) begin errors++; $display("FAIL pp_tail_w1: got %h expected 00000108", out_data); end
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got valid %b expected 0", out_valid); end
  endtask

  task automatic test_clear();
    do_clear();
    fill(0, 10);
    clear = 1'b1;
    drive_pkt(1'b1, 1'b0, 1'b0, 5'd0, 32'h99, 32'h300, 32'h0);
    tick();
    clear = 1'b0;
    trace_pkt = '0;
    checks++; if (count !== '0) begin errors++; $display("FAIL clr_count: got %0d expected 0", count); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL clr_drop: got %0d expected 0", drop_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", out_valid); end
    // intr=1 (bit30), ecause=3 in [29:25], seq restarted at 0
    drive_pkt(1'b1, 1'b0, 1'b1, 5'd3, 32'h55, 32'h200, 32'h77);
    tick();
    trace_pkt = '0;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL clr_push_count: got %0d expected 1", count); end
    checks++; if (out_data !== 32'h4600_0000) begin errors++; $display("FAIL clr_push_w0: got %h expected 46000000", out_data); end
  endtask

  task automatic test_reset_midread();
    fill(1, 2);
    out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_data !== 32'h0000_0200) begin errors++; $display("FAIL rstmid_pre: got %h expected 00000200", out_data); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_last: got %b expected 0", out_last); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rstmid_full: got %b expected 0", full); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL rstmid_drop: got %0d expected 0", drop_cnt); end
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    tick();
    fill(0, 1);
    checks++; if (out_data !== 32'h0000_0000) begin errors++; $display("FAIL rstmid_seq: got %h expected 00000000", out_data); end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_exc_filter();
    test_overflow(1'b0, 0);
    test_overflow(1'b1, 2);
    test_wrap_midread();
    test_full_push_pop();
    test_clear();
    test_reset_midread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
